// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mul_state_t;

  // Step counter must hold the values 0..N.
  function automatic int count_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/seq_multiplier_full_adder_n.sv
// N-bit ripple-carry adder; exposes the full carry vector so callers can pick the carry-out.
module Full_Adder_N #(
  parameter int REGISTER_WIDTH = 8
) (
  input  logic [REGISTER_WIDTH-1:0] a,
  input  logic [REGISTER_WIDTH-1:0] b,
  input  logic                      c_in,
  output logic [REGISTER_WIDTH-1:0] sum,
  output logic [REGISTER_WIDTH-1:0] carry
);

  always_comb begin
    logic ripple;
    ripple = c_in;
    sum    = '0;
    carry  = '0;
    for (int i = 0; i < REGISTER_WIDTH; i++) begin
      sum[i]   = a[i] ^ b[i] ^ ripple;
      carry[i] = (a[i] & b[i]) | (ripple & (a[i] ^ b[i]));
      ripple   = carry[i];
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add multiplier: one partial-product step per RUN cycle,
// 2N-bit product with a start/ready/done handshake.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int REGISTER_WIDTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [REGISTER_WIDTH-1:0]   A_i,
  input  logic [REGISTER_WIDTH-1:0]   B_i,
  output logic                        ready_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [2*REGISTER_WIDTH-1:0] P_o
);

  localparam int N  = REGISTER_WIDTH;
  localparam int CW = count_width(N);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  mul_state_t    state;
  mul_state_t    state_next;
  logic [N-1:0]  m;
  logic [N-1:0]  acc;
  logic [N-1:0]  q;
  logic [CW-1:0] count;

  logic [N-1:0]  addend;
  logic [N-1:0]  sum;
  logic [N-1:0]  carry;
  logic          c_out;
  logic          last_step;

  assign addend    = q[0] ? m : '0;
  assign c_out     = q[0] & carry[N-1];
  assign last_step = (count == LAST_STEP);

  Full_Adder_N #(
    .REGISTER_WIDTH(N)
  ) u_adder (
    .a    (acc),
    .b    (addend),
    .c_in (1'b0),
    .sum  (sum),
    .carry(carry)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state == IDLE);
    busy_o  = (state == RUN);
    done_o  = (state == DONE);
  end

  // {ACC,Q} shifts right one place per step; the carry-out becomes ACC's MSB.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      count <= '0;
      P_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            m     <= A_i;
            q     <= B_i;
            acc   <= '0;
            count <= '0;
          end
        end
        RUN: begin
          acc   <= {c_out, sum[N-1:1]};
          q     <= {sum[0], q[N-1:1]};
          count <= count + CW'(1);
          if (last_step) P_o <= {c_out, sum, q[N-1:1]};
        end
        default: ;
      endcase
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i) !(ready_o && busy_o));
  assert property (@(posedge clk_i) disable iff (rst_i) done_o |=> !done_o);

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: N=8 and N=4 instances checked every cycle against a
// timeline model, plus directed vectors with literal expected products.
module tb_seq_multiplier;

  localparam int N8 = 8;
  localparam int N4 = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0;
  logic        start4 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        ready8, busy8, done8;
  logic        ready4, busy4, done4;
  logic [15:0] p8;
  logic [7:0]  p4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.REGISTER_WIDTH(N8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .A_i(a8), .B_i(b8),
    .ready_o(ready8), .busy_o(busy8), .done_o(done8), .P_o(p8)
  );

  seq_multiplier #(.REGISTER_WIDTH(N4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .A_i(a4), .B_i(b4),
    .ready_o(ready4), .busy_o(busy4), .done_o(done4), .P_o(p4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Model: t = cycles since accept (-1 idle); RUN for t=0..N-1, DONE at t=N.
  int          t8 = -1, t4 = -1;
  logic [7:0]  ma8, mb8;
  logic [3:0]  ma4, mb4;
  logic [15:0] ep8 = '0;
  logic [7:0]  ep4 = '0;

  always @(posedge clk) begin
    if (rst) begin
      t8 = -1; ep8 = '0;
    end else if (t8 == -1) begin
      if (start8) begin t8 = 0; ma8 = a8; mb8 = b8; end
    end else if (t8 == N8) begin
      t8 = -1;
    end else begin
      t8++;
      if (t8 == N8) ep8 = 16'(ma8) * 16'(mb8);
    end

    if (rst) begin
      t4 = -1; ep4 = '0;
    end else if (t4 == -1) begin
      if (start4) begin t4 = 0; ma4 = a4; mb4 = b4; end
    end else if (t4 == N4) begin
      t4 = -1;
    end else begin
      t4++;
      if (t4 == N4) ep4 = 8'(ma4) * 8'(mb4);
    end
  end

  int cyc = 0;
  int last_done8 = -1, last_done4 = -1;
  bit spacing8_on = 0, spacing4_on = 0;

  always @(negedge clk) begin
    cyc++;
    check("ready8", ready8, (t8 == -1));
    check("busy8", busy8, (t8 >= 0 && t8 < N8));
    check("done8", done8, (t8 == N8));
    check("p8", p8, ep8);
    check("ready4", ready4, (t4 == -1));
    check("busy4", busy4, (t4 >= 0 && t4 < N4));
    check("done4", done4, (t4 == N4));
    check("p4", p4, ep4);
    if (done8) begin
      if (spacing8_on && last_done8 >= 0) check("spacing8", cyc - last_done8, N8 + 2);
      last_done8 = cyc;
    end
    if (done4) begin
      if (spacing4_on && last_done4 >= 0) check("spacing4", cyc - last_done4, N4 + 2);
      last_done4 = cyc;
    end
  end

  task automatic wait_ready8();
    int n = 0;
    while (!ready8) begin
      @(negedge clk);
      n++;
      if (n > 50) begin timeout("wait_ready8"); return; end
    end
  endtask

  // Issues one N=8 operation; lat = clock edges from accept until done_o is seen.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     output logic [15:0] p, output int lat);
    @(negedge clk);
    wait_ready8();
    a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done8) timeout("op8_done");
    p = p8;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] p;
    int lat, nd, n, k;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready8", ready8, 1);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_p8", p8, 0);
    check("rst_p4", p4, 0);
    rst = 1'b0;

    op8(8'd13, 8'd11, p, lat);
    check("p_13x11", p, 16'h008F);
    check("lat_13x11", lat, N8);
    @(negedge clk);
    check("ready_after_done", ready8, 1);

    op8(8'd255, 8'd255, p, lat);
    check("p_255x255", p, 16'hFE01);
    check("lat_255x255", lat, N8);

    op8(8'd0, 8'hAB, p, lat);
    check("p_0xAB", p, 0);
    check("lat_0xAB", lat, N8);
    op8(8'hAB, 8'd0, p, lat);
    check("p_ABx0", p, 0);
    check("lat_ABx0", lat, N8);

    // Start pulse during RUN must be ignored
    @(negedge clk);
    wait_ready8();
    a8 = 8'd7; b8 = 8'd9; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    a8 = 8'd3; b8 = 8'd3; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8) nd++;
    end
    check("ignored_start_dones", nd, 1);
    check("p_7x9", p8, 63);

    // Reset asserted during the 4th RUN cycle
    wait_ready8();
    a8 = 8'd100; b8 = 8'd200; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_rst", busy8, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_rst_ready", ready8, 1);
    check("midrun_rst_busy", busy8, 0);
    check("midrun_rst_p", p8, 0);
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8) nd++;
    end
    check("midrun_rst_no_done", nd, 0);
    op8(8'd5, 8'd6, p, lat);
    check("p_5x6", p, 30);

    // start_i held high: 200 back-to-back random operations
    @(negedge clk);
    wait_ready8();
    spacing8_on = 1; last_done8 = -1;
    start8 = 1'b1;
    k = 0; n = 0;
    while (k < 200 && n < 2200) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      @(negedge clk);
      n++;
      if (done8) k++;
    end
    start8 = 1'b0;
    check("held_start_ops", k, 200);
    @(negedge clk);
    spacing8_on = 0;

    // N=4 exhaustive, start held high
    spacing4_on = 1; last_done4 = -1;
    k = 0; n = 0;
    begin
      int idx = 0;
      while (k < 256 && n < 2000) begin
        @(negedge clk);
        n++;
        if (done4) k++;
        if (ready4 && idx < 256) begin
          a4 = 4'(idx >> 4); b4 = 4'(idx); start4 = 1'b1;
          idx++;
        end else if (idx >= 256 && !ready4) begin
          start4 = 1'b0;
        end
      end
      start4 = 1'b0;
    end
    check("exhaustive4_ops", k, 256);
    check("p4_15x15", p4, 8'd225);
    spacing4_on = 0;

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
